// File: rtl/seven_segment_scanner_if.sv
// rtl/seven_segment_scanner_if.sv - value/dot-mask load bundle feeding seven_segment_scanner
interface seven_segment_scanner_if;
  logic [31:0] din;
  logic [7:0]  dots;
  logic        din_valid;

  modport master (output din, dots, din_valid);
  modport slave  (input  din, dots, din_valid);
endinterface

// File: rtl/seven_segment_scanner.sv
// rtl/seven_segment_scanner.sv - double-buffered, guard-cycled 8-digit 7-segment scanner
// Optional leading-zero blanking: SEVEN_SEGMENT_LEADING_ZERO_BLANK_EN
module seven_segment_scanner #(
  parameter int DIGIT_CYCLES = 50000,
  parameter int NUM_DIGITS   = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  seven_segment_scanner_if.slave   load,
  output logic [7:0]               abcdefgh,
  output logic [7:0]               digit,
  output logic                     frame_sync
);
  localparam int            CW       = $clog2(DIGIT_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DIGIT_CYCLES - 1);
  localparam logic [2:0]    IDX_LAST = 3'(NUM_DIGITS - 1);

  logic [CW-1:0] cnt;
  logic [2:0]    idx;
  logic [31:0]   disp_val;
  logic [7:0]    disp_dots;
  logic [31:0]   pend_val;
  logic [7:0]    pend_dots;
  logic          pending_flag;

  logic          cnt_term;
  logic          commit;
  logic [3:0]    nib;
  logic          dot_bit;
  logic [6:0]    seg;
  logic          blank;

  assign cnt_term = (cnt == CNT_LAST);
  assign commit   = cnt_term && (idx == IDX_LAST);
  assign nib      = disp_val[{idx, 2'b00} +: 4];
  assign dot_bit  = disp_dots[idx];

  always_comb begin
    seg = 7'b0000000;
    case (nib)
      4'h0: seg = 7'b1111110;
      4'h1: seg = 7'b0110000;
      4'h2: seg = 7'b1101101;
      4'h3: seg = 7'b1111001;
      4'h4: seg = 7'b0110011;
      4'h5: seg = 7'b1011011;
      4'h6: seg = 7'b1011111;
      4'h7: seg = 7'b1110000;
      4'h8: seg = 7'b1111111;
      4'h9: seg = 7'b1111011;
      4'hA: seg = 7'b1110111;
      4'hB: seg = 7'b0011111;
      4'hC: seg = 7'b1001110;
      4'hD: seg = 7'b0111101;
      4'hE: seg = 7'b1001111;
      4'hF: seg = 7'b1000111;
      default: seg = 7'b0000000;
    endcase
  end

`ifdef SEVEN_SEGMENT_LEADING_ZERO_BLANK_EN
  // lead_zero[k]: nibble and dot at k and every populated position above it are all zero
  logic [7:0] lead_zero;
  always_comb begin
    logic run;
    run       = 1'b1;
    lead_zero = '0;
    for (int k = 7; k >= 0; k--) begin
      if (k < NUM_DIGITS) begin
        run          = run && (disp_val[4*k +: 4] == 4'h0) && !disp_dots[k];
        lead_zero[k] = run;
      end
    end
  end
  assign blank = (idx != 3'd0) && lead_zero[idx];
`else
  assign blank = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt          <= '0;
      idx          <= '0;
      disp_val     <= '0;
      disp_dots    <= '0;
      pend_val     <= '0;
      pend_dots    <= '0;
      pending_flag <= 1'b0;
      frame_sync   <= 1'b0;
      digit        <= 8'hFF;
      abcdefgh     <= 8'hFF;
    end else begin
      cnt <= cnt_term ? '0 : cnt + 1'b1;
      if (cnt_term)
        idx <= (idx == IDX_LAST) ? 3'd0 : idx + 1'b1;
      frame_sync <= commit;

      // A strobe landing on the commit cycle bypasses pending so it cannot be lost or go stale
      if (commit && load.din_valid) begin
        disp_val     <= load.din;
        disp_dots    <= load.dots;
        pending_flag <= 1'b0;
      end else if (commit && pending_flag) begin
        disp_val     <= pend_val;
        disp_dots    <= pend_dots;
        pending_flag <= 1'b0;
      end else if (load.din_valid) begin
        pend_val     <= load.din;
        pend_dots    <= load.dots;
        pending_flag <= 1'b1;
      end

      if (cnt == '0) begin
        digit    <= 8'hFF;
        abcdefgh <= 8'hFF;
      end else begin
        digit    <= ~(8'd1 << idx);
        abcdefgh <= blank ? 8'hFF : {~seg, ~dot_bit};
      end
    end
  end
endmodule

// File: tb/tb_seven_segment_scanner.sv
// tb/tb_seven_segment_scanner.sv - scoreboard bench for seven_segment_scanner
module tb_seven_segment_scanner;
  localparam int DC = 4;
  localparam int ND = 8;

  typedef struct packed {
    logic [7:0] dig;
    logic [7:0] seg;
    logic       fs;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] abcdefgh;
  logic [7:0] digit;
  logic       frame_sync;
  exp_t       sb[$];
  int         tests = 0;
  int         fails = 0;

  seven_segment_scanner_if bus();

  seven_segment_scanner #(.DIGIT_CYCLES(DC), .NUM_DIGITS(ND)) dut (
    .clk(clk),
    .reset(reset),
    .load(bus),
    .abcdefgh(abcdefgh),
    .digit(digit),
    .frame_sync(frame_sync)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] hex7(input logic [3:0] n);
    logic [6:0] tbl [16];
    tbl = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
            7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
            7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
            7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111};
    return tbl[n];
  endfunction

  function automatic logic [7:0] exp_seg(input logic [31:0] v, input logic [7:0] d, input int k);
    logic blank;
    blank = 1'b0;
`ifdef SEVEN_SEGMENT_LEADING_ZERO_BLANK_EN
    if (k > 0) begin
      blank = 1'b1;
      for (int j = k; j < ND; j++)
        if (v[4*j +: 4] != 4'h0 || d[j]) blank = 1'b0;
    end
`endif
    return blank ? 8'hFF : {~hex7(v[4*k +: 4]), ~d[k]};
  endfunction

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic push_frame(input logic [31:0] v, input logic [7:0] d);
    exp_t e;
    for (int k = 0; k < ND; k++)
      for (int c = 0; c < DC; c++) begin
        e.fs  = (k == ND - 1) && (c == DC - 1);
        e.dig = (c == 0) ? 8'hFF : ~(8'd1 << k);
        e.seg = (c == 0) ? 8'hFF : exp_seg(v, d, k);
        sb.push_back(e);
      end
  endtask

  // Samples n cycles; strobe slots sa/sb2 (-1 = unused) drive din_valid into the following edge
  task automatic run(input int n,
                     input int sa,  input logic [31:0] da, input logic [7:0] ta,
                     input int sb2, input logic [31:0] db, input logic [7:0] tb2);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      tests++;
      assert (sb.size() != 0) else begin
        fails++;
        $error("FAIL scoreboard_empty: observed 0 entries expected >0");
      end
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check($sformatf("digit[%0d]", i), digit, e.dig);
        check($sformatf("abcdefgh[%0d]", i), abcdefgh, e.seg);
        check($sformatf("frame_sync[%0d]", i), {7'd0, frame_sync}, {7'd0, e.fs});
      end
      bus.din_valid = 1'b0;
      bus.din       = $urandom;
      bus.dots      = 8'($urandom);
      if (i == sa)  begin bus.din_valid = 1'b1; bus.din = da; bus.dots = ta;  end
      if (i == sb2) begin bus.din_valid = 1'b1; bus.din = db; bus.dots = tb2; end
    end
  endtask

  initial begin
    bus.din       = '0;
    bus.dots      = '0;
    bus.din_valid = 1'b0;
    #1 reset = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_digit", digit, 8'hFF);
    check("reset_abcdefgh", abcdefgh, 8'hFF);
    check("reset_frame_sync", {7'd0, frame_sync}, 8'h00);
    reset = 1'b1;

    push_frame(32'h0, 8'h00);
    run(32, -1, 32'h0, 8'h0, -1, 32'h0, 8'h0);
    push_frame(32'h0, 8'h00);
    run(32, 10, 32'h0123_4567, 8'h01, -1, 32'h0, 8'h0);
    push_frame(32'h0123_4567, 8'h01);
    run(32, 5, 32'h1111_1111, 8'h00, 6, 32'hFFFF_FFFF, 8'h00);
    push_frame(32'hFFFF_FFFF, 8'h00);
    run(32, 10, 32'h5555_5555, 8'h00, 30, 32'hAAAA_AAAA, 8'h00);
    push_frame(32'hAAAA_AAAA, 8'h00);
    run(32, -1, 32'h0, 8'h0, -1, 32'h0, 8'h0);
    push_frame(32'hAAAA_AAAA, 8'h00);
    run(32, 20, 32'h0000_0042, 8'h00, -1, 32'h0, 8'h0);
    push_frame(32'h0000_0042, 8'h00);
    run(32, -1, 32'h0, 8'h0, -1, 32'h0, 8'h0);

    // Stop with idx=5, cnt=2 pending, then reset between clock edges
    push_frame(32'h0000_0042, 8'h00);
    run(22, -1, 32'h0, 8'h0, -1, 32'h0, 8'h0);
    #2 reset = 1'b0;
    #1;
    check("async_reset_digit", digit, 8'hFF);
    check("async_reset_abcdefgh", abcdefgh, 8'hFF);
    check("async_reset_frame_sync", {7'd0, frame_sync}, 8'h00);
    sb.delete();
    @(negedge clk);
    reset = 1'b1;
    push_frame(32'h0, 8'h00);
    run(32, -1, 32'h0, 8'h0, -1, 32'h0, 8'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
